// File: rtl/edge_list_tx_if.sv
// Valid/ready byte stream carrying edge-list packets toward the rover control link.
interface edge_list_tx_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/edge_list_tx.sv
// Snapshots the per-frame edge list on frame_done and streams it as a framed packet:
// header, valid-entry count, two bytes per edge, XOR checksum.
module edge_list_tx #(
  parameter int          LIST_LEN = 30,
  parameter int          X_W      = 11,
  parameter logic [7:0]  HDR      = 8'hA5
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              frame_done,
  input  logic [LIST_LEN-1:0][X_W-1:0]      measured_list,
  edge_list_tx_if.master                    out_if,
  output logic                              busy,
  output logic [7:0]                        dropped_frames
);

  localparam int IW = $clog2(LIST_LEN + 1);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_HDR, S_CNT, S_HI, S_LO, S_CSUM} state_t;

  state_t                         state, state_next;
  logic [LIST_LEN-1:0][X_W-1:0]   snap;
  logic [IW-1:0]                  idx;
  logic [7:0]                     count;
  logic [7:0]                     csum;
  logic [X_W-1:0]                 cur_entry;
  logic                           scan_done;
  logic                           xfer;
  logic                           valid_c;
  logic                           last_c;
  logic [7:0]                     data_c;

  // idx walks the list during SCAN, then is reused as the entry pointer while emitting
  always_comb begin
    cur_entry = '0;
    for (int i = 0; i < LIST_LEN; i++) begin
      if (idx == IW'(i)) cur_entry = snap[i];
    end
  end

  assign scan_done = (idx == IW'(LIST_LEN)) || (cur_entry == '0);
  assign xfer      = valid_c && out_if.out_ready;

  assign out_if.out_valid = valid_c;
  assign out_if.out_data  = data_c;
  assign out_if.out_last  = last_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    valid_c    = 1'b0;
    data_c     = 8'h00;
    last_c     = 1'b0;
    case (state)
      S_IDLE: if (frame_done) state_next = S_SCAN;
      S_SCAN: if (scan_done)  state_next = S_HDR;
      S_HDR: begin
        valid_c = 1'b1;
        data_c  = HDR;
        if (xfer) state_next = S_CNT;
      end
      S_CNT: begin
        valid_c = 1'b1;
        data_c  = count;
        if (xfer) state_next = (count != 8'd0) ? S_HI : S_CSUM;
      end
      S_HI: begin
        valid_c = 1'b1;
        data_c  = 8'(cur_entry[X_W-1:8]);
        if (xfer) state_next = S_LO;
      end
      S_LO: begin
        valid_c = 1'b1;
        data_c  = cur_entry[7:0];
        if (xfer) state_next = ((8'(idx) + 8'd1) < count) ? S_HI : S_CSUM;
      end
      S_CSUM: begin
        valid_c = 1'b1;
        data_c  = csum;
        last_c  = 1'b1;
        if (xfer) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Snapshot, scan bookkeeping, running checksum and the dropped-frame counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap           <= '0;
      idx            <= '0;
      count          <= 8'h00;
      csum           <= 8'h00;
      dropped_frames <= 8'h00;
      busy           <= 1'b0;
    end else begin
      busy <= (state_next != S_IDLE);
      if (frame_done && (state != S_IDLE) && (dropped_frames != 8'hFF))
        dropped_frames <= dropped_frames + 8'd1;
      if (xfer)
        csum <= csum ^ data_c;
      case (state)
        S_IDLE: begin
          if (frame_done) begin
            snap <= measured_list;
            idx  <= '0;
            csum <= 8'h00;
          end
        end
        S_SCAN: begin
          if (scan_done) begin
            count <= 8'(idx);
            idx   <= '0;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        S_LO: if (xfer) idx <= idx + IW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_edge_list_tx.sv
// Directed bench for edge_list_tx: a packet-level model predicts every byte, busy and
// dropped_frames; directed tests pin literal packets, scan latency and backpressure hold.
module tb_edge_list_tx;

  localparam int LIST_LEN = 30;
  localparam int X_W      = 11;

  typedef logic [LIST_LEN-1:0][X_W-1:0] list_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_done = 1'b0;
  list_t      measured_list = '0;
  logic       busy;
  logic [7:0] dropped_frames;

  edge_list_tx_if bus();

  edge_list_tx #(.LIST_LEN(LIST_LEN), .X_W(X_W), .HDR(8'hA5)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .frame_done     (frame_done),
    .measured_list  (measured_list),
    .out_if         (bus),
    .busy           (busy),
    .dropped_frames (dropped_frames)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] expQ[$];
  logic [7:0] captured[$];
  bit         modelBusy = 1'b0;
  int         modelDropped = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Packet derived straight from the list: leading non-zero entries, split into hi/lo, XOR trailer
  function automatic void buildPacket(input list_t l);
    logic [7:0] pkt[$];
    logic [7:0] x;
    int         n;
    n = 0;
    while (n < LIST_LEN && l[n] != '0) n++;
    pkt.push_back(8'hA5);
    pkt.push_back(8'(n));
    for (int k = 0; k < n; k++) begin
      pkt.push_back(8'(l[k] >> 8));
      pkt.push_back(8'(l[k] & 11'h0FF));
    end
    x = 8'h00;
    foreach (pkt[i]) x = x ^ pkt[i];
    pkt.push_back(x);
    foreach (pkt[i]) expQ.push_back(pkt[i]);
  endfunction

  always @(negedge clk) begin
    bit wasBusy;
    if (!reset_n) begin
      checkOutput("rstValid", bus.out_valid, 0);
      checkOutput("rstLast", bus.out_last, 0);
      checkOutput("rstData", bus.out_data, 0);
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstDropped", dropped_frames, 0);
      expQ.delete();
      captured.delete();
      modelBusy    = 1'b0;
      modelDropped = 0;
    end else begin
      wasBusy = modelBusy;
      checkOutput("busy", busy, modelBusy);
      checkOutput("dropped", dropped_frames, modelDropped);
      if (bus.out_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedByte", bus.out_valid, 0);
        end else begin
          checkOutput("data", bus.out_data, expQ[0]);
          checkOutput("last", bus.out_last, (expQ.size() == 1));
          if (bus.out_ready) begin
            captured.push_back(bus.out_data);
            void'(expQ.pop_front());
            if (expQ.size() == 0) modelBusy = 1'b0;
          end
        end
      end
      if (frame_done) begin
        if (wasBusy) begin
          if (modelDropped < 255) modelDropped++;
        end else begin
          buildPacket(measured_list);
          modelBusy = 1'b1;
        end
      end
    end
  end

  task automatic doReset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Pulses frame_done for one edge and counts edges until the header byte is presented
  task automatic applyStimulus(input list_t lst, output int scan);
    captured.delete();
    measured_list = lst;
    frame_done    = 1'b1;
    @(posedge clk);
    #1;
    frame_done = 1'b0;
    scan = 0;
    while (!bus.out_valid && scan < 100) begin
      @(posedge clk);
      #1;
      scan++;
    end
  endtask

  task automatic waitIdle();
    int c;
    c = 0;
    while ((modelBusy || expQ.size() != 0) && c < 500) begin
      @(posedge clk);
      #1;
      c++;
    end
    checkOutput("idleTimeout", (c < 500), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic checkPacket(input string name, input logic [7:0] exp[$]);
    checkOutput({name, "Len"}, captured.size(), exp.size());
    for (int i = 0; i < exp.size() && i < captured.size(); i++)
      checkOutput($sformatf("%sByte%0d", name, i), captured[i], exp[i]);
  endtask

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    list_t      l;
    int         scan;
    int         c;
    logic [7:0] exp[$];

    bus.out_ready = 1'b1;
    doReset();
    checkOutput("initValid", bus.out_valid, 0);
    checkOutput("initData", bus.out_data, 8'h00);
    checkOutput("initBusy", busy, 0);
    checkOutput("initDropped", dropped_frames, 0);

    // Empty list
    l = '0;
    applyStimulus(l, scan);
    checkOutput("emptyScan", scan, 1);
    waitIdle();
    exp = '{8'hA5, 8'h00, 8'hA5};
    checkPacket("empty", exp);
    checkOutput("emptyBusyAfter", busy, 0);

    // Single entry
    l = '0;
    l[0] = 11'd100;
    applyStimulus(l, scan);
    checkOutput("singleScan", scan, 2);
    waitIdle();
    exp = '{8'hA5, 8'h01, 8'h00, 8'h64, 8'hC0};
    checkPacket("single", exp);

    // Entry after the first zero ignored; list changes after latching have no effect
    l = '0;
    l[0] = 11'd100;
    l[1] = 11'd600;
    l[3] = 11'd200;
    applyStimulus(l, scan);
    measured_list = '1;
    checkOutput("gapScan", scan, 3);
    waitIdle();
    exp = '{8'hA5, 8'h02, 8'h00, 8'h64, 8'h02, 8'h58, 8'h99};
    checkPacket("gap", exp);

    // Full list
    for (int k = 0; k < LIST_LEN; k++) l[k] = 11'(40 + 10 * k);
    applyStimulus(l, scan);
    checkOutput("fullScan", scan, 31);
    waitIdle();
    checkOutput("fullLen", captured.size(), 63);
    checkOutput("fullCnt", captured[1], 8'h1E);

    // Backpressure while the first LO byte is presented
    l = '0;
    l[0] = 11'h123;
    l[1] = 11'h7FF;
    l[2] = 11'h005;
    applyStimulus(l, scan);
    c = 0;
    while (captured.size() < 3 && c < 100) begin
      @(posedge clk);
      #1;
      c++;
    end
    checkOutput("bpReachLo", (c < 100), 1);
    bus.out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checkOutput("bpHoldValid", bus.out_valid, 1);
      checkOutput("bpHoldData", bus.out_data, 8'h23);
      checkOutput("bpHoldLast", bus.out_last, 0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    waitIdle();
    exp = '{8'hA5, 8'h03, 8'h01, 8'h23, 8'h07, 8'hFF, 8'h00, 8'h05, 8'h79};
    checkPacket("bp", exp);

    // frame_done on the same edge the checksum byte transfers is dropped
    l = '0;
    l[0] = 11'd100;
    applyStimulus(l, scan);
    c = 0;
    while (!bus.out_last && c < 100) begin
      @(posedge clk);
      #1;
      c++;
    end
    checkOutput("csumReach", (c < 100), 1);
    frame_done = 1'b1;
    @(posedge clk);
    #1;
    frame_done = 1'b0;
    checkOutput("csumDrop", dropped_frames, 1);
    checkOutput("csumBusy", busy, 0);
    waitIdle();
    exp = '{8'hA5, 8'h01, 8'h00, 8'h64, 8'hC0};
    checkPacket("csumPkt", exp);

    // Drops while busy, then reset mid-packet, then a fresh packet
    doReset();
    for (int k = 0; k < LIST_LEN; k++) l[k] = 11'(40 + 10 * k);
    applyStimulus(l, scan);
    repeat (4) @(posedge clk);
    #1;
    frame_done = 1'b1;
    @(posedge clk);
    #1;
    frame_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    frame_done = 1'b1;
    @(posedge clk);
    #1;
    frame_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("dropTwice", dropped_frames, 2);
    checkOutput("dropBusy", busy, 1);
    checkOutput("dropInFlight", (captured.size() > 5), 1);
    reset_n = 1'b0;
    #1;
    checkOutput("midRstValid", bus.out_valid, 0);
    checkOutput("midRstDropped", dropped_frames, 0);
    checkOutput("midRstBusy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("postRstValid", bus.out_valid, 0);
    l = '0;
    l[0] = 11'd100;
    applyStimulus(l, scan);
    checkOutput("postRstScan", scan, 2);
    waitIdle();
    exp = '{8'hA5, 8'h01, 8'h00, 8'h64, 8'hC0};
    checkPacket("postRst", exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
